// File: rtl/spi_oled_pkg.sv
// -----------------------------------------------------------------------------
// spi_oled_pkg
// Shared definitions for the SPI OLED receiver: default FIFO depth, bit
// positions of the status word and of the data-read word, the FIFO entry
// layout and the read-select decode used by the register read port.
// -----------------------------------------------------------------------------
package spi_oled_pkg;

    localparam int FIFO_DEPTH_DEFAULT = 4;

    // Status word bit positions
    localparam int STAT_NONEMPTY  = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERFLOW  = 2;
    localparam int STAT_FRAME_ERR = 3;
    localparam int STAT_RST_LVL   = 4;
    localparam int STAT_CNT_LSB   = 5;
    localparam int STAT_CNT_MSB   = 8;

    // Data read word bit positions
    localparam int DAT_BYTE_LSB = 0;
    localparam int DAT_BYTE_MSB = 7;
    localparam int DAT_DC       = 8;
    localparam int DAT_VALID    = 9;

    typedef struct packed {
        logic       dc;
        logic [7:0] data;
    } rx_entry_t;

    typedef enum logic [1:0] {
        RD_NONE,
        RD_DAT,
        RD_STAT
    } rd_sel_e;

    // A data select takes priority if software asserts both selects.
    function automatic rd_sel_e decode_read(input logic strobe,
                                            input logic sel_dat,
                                            input logic sel_stat);
        if (!strobe)  return RD_NONE;
        if (sel_dat)  return RD_DAT;
        if (sel_stat) return RD_STAT;
        return RD_NONE;
    endfunction

endpackage

// File: rtl/spi_oled_rx_if.sv
// -----------------------------------------------------------------------------
// spi_oled_rx_if
// Bundles the host read port (rstrb, sel_dat, sel_stat, rdata, irq) and the
// OLED-side serial pins (SCK, DIN, CS, DC, RST).
//   slave  : the receiver (serial pins and read controls are inputs)
//   master : the environment driving the pins and issuing reads
// -----------------------------------------------------------------------------
interface spi_oled_rx_if;
    logic        rstrb;
    logic        sel_dat;
    logic        sel_stat;
    logic [31:0] rdata;
    logic        irq;
    logic        SCK;
    logic        DIN;
    logic        CS;
    logic        DC;
    logic        RST;

    modport slave (
        input  rstrb, sel_dat, sel_stat, SCK, DIN, CS, DC, RST,
        output rdata, irq
    );

    modport master (
        output rstrb, sel_dat, sel_stat, SCK, DIN, CS, DC, RST,
        input  rdata, irq
    );
endinterface

// File: rtl/spi_oled_rx_fifo.sv
// -----------------------------------------------------------------------------
// spi_oled_rx_fifo
// Synchronous FIFO of received {DC, byte} entries.
//   clk, reset : clock, asynchronous active-high reset
//   flush_i    : empties the FIFO (pointers and count to zero)
//   push_i     : write wdata_i; accepted when not full, or when full and a
//                pop happens in the same cycle
//   pop_i      : drop the head entry (ignored when empty)
//   rdata_o    : head entry, combinational
//   full_o, empty_o, count_o : occupancy
// -----------------------------------------------------------------------------
module spi_oled_rx_fifo
    import spi_oled_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEFAULT,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  rx_entry_t     wdata_i,
    output rx_entry_t     rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    rx_entry_t     mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // When full, a push only fits because the simultaneous pop frees the slot;
    // wr_ptr then equals rd_ptr and the head is read before it is overwritten.
    assign do_pop  = pop_i & ~empty_o & ~flush_i;
    assign do_push = push_i & (~full_o | do_pop) & ~flush_i;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/spi_oled_rx.sv
// -----------------------------------------------------------------------------
// spi_oled_rx
// SPI receiver for an OLED-style write-only link. Bytes clocked in on SCK
// while CS is low are tagged with DC and queued in a FIFO that the host reads
// through a strobed register port.
//   clk, reset : system clock, asynchronous active-high reset
//   bus        : spi_oled_rx_if.slave
//       rstrb/sel_dat  -> pop one entry: rdata = {valid, DC, byte}
//       rstrb/sel_stat -> status word; clears OVERFLOW and FRAME_ERR
//       rdata          -> registered read data
//       irq            -> FIFO non-empty
//       SCK/DIN/CS/DC/RST -> asynchronous serial pins
// -----------------------------------------------------------------------------
module spi_oled_rx
    import spi_oled_pkg::*;
#(
    parameter int FIFO_DEPTH   = FIFO_DEPTH_DEFAULT,
    parameter int SCK_MIN_HALF = 2
) (
    input logic         clk,
    input logic         reset,
    spi_oled_rx_if.slave bus
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // SCK must stay at each level long enough to cross the two-flop
    // synchronizer and still be seen as a single edge.
    generate
        if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
            (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || SCK_MIN_HALF < 2) begin : g_bad_param
            $error("spi_oled_rx: unsupported FIFO_DEPTH or SCK_MIN_HALF");
        end
    endgenerate

    logic [2:0]    sck_q;
    logic [1:0]    din_q, cs_q, dc_q, rst_q;
    logic          cs_prev_q;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic          ovf_q, ovf_d, ferr_q, ferr_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          sck_rise, cs_rise, rst_active, sample;
    logic [7:0]    next_byte;
    logic          push, pop, ovf_set, ferr_set, stat_clr;
    rx_entry_t     head;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [4:0]    count_ext;
    logic [3:0]    count_field;
    logic [31:0]   stat_word;
    rd_sel_e       rd_sel;

    // Pin synchronizers; reset leaves them at the idle levels of the link.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_q     <= 3'b000;
            din_q     <= 2'b00;
            cs_q      <= 2'b11;
            dc_q      <= 2'b00;
            rst_q     <= 2'b11;
            cs_prev_q <= 1'b1;
        end else begin
            sck_q     <= {sck_q[1:0], bus.SCK};
            din_q     <= {din_q[0], bus.DIN};
            cs_q      <= {cs_q[0], bus.CS};
            dc_q      <= {dc_q[0], bus.DC};
            rst_q     <= {rst_q[0], bus.RST};
            cs_prev_q <= cs_q[1];
        end
    end

    assign sck_rise   = sck_q[1] & ~sck_q[2];
    assign cs_rise    = cs_q[1] & ~cs_prev_q;
    assign rst_active = ~rst_q[1];
    assign sample     = sck_rise & ~cs_q[1] & ~rst_active;
    assign next_byte  = {shift_q[6:0], din_q[1]};

    // Shift in one bit per qualified SCK edge; the eighth bit pushes the
    // completed byte straight from the shifter input so no cycle is lost.
    always_comb begin
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        push     = 1'b0;
        ferr_set = 1'b0;
        if (rst_active) begin
            shift_d  = '0;
            bitcnt_d = '0;
        end else if (sample) begin
            shift_d = next_byte;
            if (bitcnt_q == 3'd7) begin
                push     = 1'b1;
                bitcnt_d = '0;
            end else begin
                bitcnt_d = bitcnt_q + 3'd1;
            end
        end else if (cs_rise && bitcnt_q != 3'd0) begin
            shift_d  = '0;
            bitcnt_d = '0;
            ferr_set = 1'b1;
        end
    end

    spi_oled_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (rst_active),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({dc_q[1], next_byte}),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // A push into a full FIFO is only lost when no pop frees a slot.
    assign ovf_set = push & fifo_full & ~pop;

    // The count field is four bits wide; a full 16-deep FIFO saturates it at
    // 15 and the full bit tells the two cases apart.
    assign count_ext   = 5'(fifo_count);
    assign count_field = (count_ext > 5'd15) ? 4'd15 : count_ext[3:0];

    always_comb begin
        stat_word                             = '0;
        stat_word[STAT_NONEMPTY]              = ~fifo_empty;
        stat_word[STAT_FULL]                  = fifo_full;
        stat_word[STAT_OVERFLOW]              = ovf_q;
        stat_word[STAT_FRAME_ERR]             = ferr_q;
        stat_word[STAT_RST_LVL]               = rst_q[1];
        stat_word[STAT_CNT_MSB:STAT_CNT_LSB]  = count_field;
    end

    assign rd_sel = decode_read(bus.rstrb, bus.sel_dat, bus.sel_stat);

    // Read port: data reads pop the head, status reads clear the sticky
    // flags; a strobe without a select leaves rdata untouched.
    always_comb begin
        rdata_d  = rdata_q;
        pop      = 1'b0;
        stat_clr = 1'b0;
        case (rd_sel)
            RD_DAT: begin
                rdata_d = '0;
                if (!fifo_empty) begin
                    rdata_d[DAT_BYTE_MSB:DAT_BYTE_LSB] = head.data;
                    rdata_d[DAT_DC]                    = head.dc;
                    rdata_d[DAT_VALID]                 = 1'b1;
                    pop                                = 1'b1;
                end
            end
            RD_STAT: begin
                rdata_d  = stat_word;
                stat_clr = 1'b1;
            end
            default: ;
        endcase
        // A new error event in the clearing cycle stays visible.
        ovf_d  = (ovf_q & ~stat_clr) | ovf_set;
        ferr_d = (ferr_q & ~stat_clr) | ferr_set;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q  <= '0;
            bitcnt_q <= '0;
            ovf_q    <= 1'b0;
            ferr_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            ovf_q    <= ovf_d;
            ferr_q   <= ferr_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.rdata = rdata_q;
    assign bus.irq   = ~fifo_empty;

endmodule

// File: tb/tb_spi_oled_rx.sv
// -----------------------------------------------------------------------------
// tb_spi_oled_rx
// Directed bench for spi_oled_rx with FIFO_DEPTH=4. Reads push their expected
// rdata into a queue; an independent monitor pops and compares one cycle
// after each qualified read strobe.
// -----------------------------------------------------------------------------
module tb_spi_oled_rx;

    logic clk = 1'b0;
    logic reset;

    spi_oled_rx_if bus ();

    spi_oled_rx #(.FIFO_DEPTH(4), .SCK_MIN_HALF(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          nCompared   = 0;
    int          nMismatched = 0;
    logic [31:0] expQ[$];
    string       nameQ[$];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCK period: data and DC set while SCK is low, then SCK high.
    task automatic applyStimulus(input logic din, input logic dc, input int half);
        bus.DIN = din;
        bus.DC  = dc;
        waitCycles(half);
        bus.SCK = 1'b1;
        waitCycles(half);
        bus.SCK = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b, input logic dc);
        for (int i = 7; i >= 0; i--) applyStimulus(b[i], dc, 2);
        waitCycles(4);
    endtask

    // Last bit's push lands on the third clk edge after SCK rises; the data
    // read strobe is placed so it is sampled on that same edge.
    task automatic sendBytePop(input logic [7:0] b, input logic dc,
                               input logic [31:0] popExp);
        for (int i = 7; i >= 1; i--) applyStimulus(b[i], dc, 2);
        bus.DIN = b[0];
        bus.DC  = dc;
        waitCycles(2);
        bus.SCK = 1'b1;
        waitCycles(2);
        bus.rstrb   = 1'b1;
        bus.sel_dat = 1'b1;
        expQ.push_back(popExp);
        nameQ.push_back("popOnPush");
        bus.SCK = 1'b0;
        waitCycles(1);
        bus.rstrb   = 1'b0;
        bus.sel_dat = 1'b0;
        waitCycles(4);
    endtask

    task automatic readDat(input logic [31:0] expected, input string name);
        expQ.push_back(expected);
        nameQ.push_back(name);
        bus.rstrb   = 1'b1;
        bus.sel_dat = 1'b1;
        waitCycles(1);
        bus.rstrb   = 1'b0;
        bus.sel_dat = 1'b0;
        waitCycles(1);
    endtask

    task automatic readStat(input logic [31:0] expected, input string name);
        expQ.push_back(expected);
        nameQ.push_back(name);
        bus.rstrb    = 1'b1;
        bus.sel_stat = 1'b1;
        waitCycles(1);
        bus.rstrb    = 1'b0;
        bus.sel_stat = 1'b0;
        waitCycles(1);
    endtask

    // Monitor: a qualified strobe seen on a rising edge means rdata holds the
    // answer after that edge.
    initial begin
        forever begin
            @(posedge clk);
            if (!reset && bus.rstrb && (bus.sel_dat || bus.sel_stat)) begin
                @(negedge clk);
                if (expQ.size() == 0) begin
                    nCompared++;
                    nMismatched++;
                    $display("[TB] FAIL unexpectedRead: got 0x%08h, expected no read", bus.rdata);
                end else begin
                    checkOutput(nameQ.pop_front(), bus.rdata, expQ.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Status word values: bit0 nonempty, bit1 full, bit2 overflow,
    // bit3 frame error, bit4 RST level, bits[8:5] count.
    initial begin
        reset        = 1'b1;
        bus.rstrb    = 1'b0;
        bus.sel_dat  = 1'b0;
        bus.sel_stat = 1'b0;
        bus.SCK      = 1'b0;
        bus.DIN      = 1'b0;
        bus.CS       = 1'b1;
        bus.DC       = 1'b0;
        bus.RST      = 1'b1;
        waitCycles(3);
        checkOutput("resetRdata", bus.rdata, 32'h0);
        checkOutput("resetIrq", {31'b0, bus.irq}, 32'h0);
        reset = 1'b0;
        waitCycles(3);
        readStat(32'h010, "statIdle");

        // Single command byte
        bus.CS = 1'b0;
        waitCycles(3);
        sendByte(8'hA5, 1'b0);
        checkOutput("irqOneByte", {31'b0, bus.irq}, 32'h1);
        readStat(32'h031, "statOneByte");
        readDat(32'h2A5, "datA5");
        bus.rstrb = 1'b1;
        waitCycles(1);
        bus.rstrb = 1'b0;
        waitCycles(1);
        checkOutput("noSelHold", bus.rdata, 32'h2A5);
        readDat(32'h000, "datEmpty");

        // Clean deselect, then SCK activity while deselected
        bus.CS = 1'b1;
        waitCycles(3);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 2);
        waitCycles(4);
        readStat(32'h010, "statCsHigh");
        bus.CS = 1'b0;
        waitCycles(3);

        // Overflow with five bytes into four slots
        for (int i = 1; i <= 5; i++) sendByte(8'(i), 1'b1);
        readStat(32'h097, "statOverflow");
        readStat(32'h093, "statOvfCleared");
        readDat(32'h301, "dat01");
        readDat(32'h302, "dat02");
        readDat(32'h303, "dat03");
        readDat(32'h304, "dat04");
        readDat(32'h000, "datDrained");

        // Partial byte aborted by CS, then a clean byte
        applyStimulus(1'b1, 1'b0, 2);
        applyStimulus(1'b0, 1'b0, 2);
        applyStimulus(1'b1, 1'b0, 2);
        bus.CS = 1'b1;
        waitCycles(5);
        readStat(32'h018, "statFrameErr");
        bus.CS = 1'b0;
        waitCycles(3);
        sendByte(8'h3C, 1'b1);
        readStat(32'h031, "statAfterFrame");
        readDat(32'h33C, "dat3C");

        // Full FIFO with push and pop on the same edge
        for (int i = 0; i < 4; i++) sendByte(8'(8'h10 + i), 1'b0);
        readStat(32'h093, "statFullNoOvf");
        sendBytePop(8'h14, 1'b0, 32'h210);
        readStat(32'h093, "statPushPop");
        readDat(32'h211, "dat11");
        readDat(32'h212, "dat12");
        readDat(32'h213, "dat13");
        readDat(32'h214, "dat14");
        readStat(32'h010, "statPushPopDone");

        // Display reset flushes the queue and masks SCK
        sendByte(8'h55, 1'b0);
        sendByte(8'hAA, 1'b1);
        readStat(32'h051, "statTwoQueued");
        bus.RST = 1'b0;
        waitCycles(1);
        bus.SCK = 1'b1;
        waitCycles(1);
        bus.SCK = 1'b0;
        waitCycles(1);
        expQ.push_back(32'h000);
        nameQ.push_back("statDuringRst");
        bus.rstrb    = 1'b1;
        bus.sel_stat = 1'b1;
        waitCycles(1);
        bus.rstrb    = 1'b0;
        bus.sel_stat = 1'b0;
        bus.RST      = 1'b1;
        waitCycles(6);
        checkOutput("irqAfterRst", {31'b0, bus.irq}, 32'h0);
        readStat(32'h010, "statAfterRst");
        sendByte(8'h81, 1'b0);
        readDat(32'h281, "dat81");

        // Reset in the middle of a byte
        sendByte(8'h77, 1'b0);
        applyStimulus(1'b1, 1'b1, 2);
        applyStimulus(1'b0, 1'b1, 2);
        applyStimulus(1'b1, 1'b1, 2);
        applyStimulus(1'b0, 1'b1, 2);
        reset = 1'b1;
        waitCycles(1);
        checkOutput("midResetRdata", bus.rdata, 32'h0);
        checkOutput("midResetIrq", {31'b0, bus.irq}, 32'h0);
        waitCycles(2);
        reset = 1'b0;
        waitCycles(4);
        readStat(32'h010, "statAfterReset");
        sendByte(8'hC3, 1'b1);
        readDat(32'h3C3, "datC3");
        readStat(32'h010, "statFinal");

        waitCycles(3);
        checkOutput("queueDrained", 32'(expQ.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/spi_oled_rx.md
SPI_OLED_RX -- requirements
Module: spi_oled_rx

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, entries in the receive FIFO; power of two, 2..16.
REQ-002 Parameter: SCK_MIN_HALF, 2, minimum SCK high or low time, in clk cycles, that the block SHALL tolerate.
REQ-003 clk  in  1  system clock; all state SHALL be clocked on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 rstrb  in  1  read strobe; qualified by one sel_xxx.
REQ-006 sel_dat  in  1  read and pop one FIFO entry.
REQ-007 sel_stat  in  1  read the status word.
REQ-008 rdata  out  32  read data, registered.
REQ-009 SCK  in  1  serial clock from the OLED-side master; asynchronous to clk.
REQ-010 DIN  in  1  serial data, MSB first.
REQ-011 CS  in  1  chip select, active low.
REQ-012 DC  in  1  1 = data byte, 0 = command byte.
REQ-013 RST  in  1  display reset, active low.
REQ-014 irq  out  1  high while the FIFO is non-empty.

Function
REQ-015 SCK, DIN, CS, DC and RST SHALL each pass through a 2-flop synchronizer; a third SCK flop SHALL provide edge detection.
REQ-016 Sampling: on a synchronized SCK rising edge while synced CS=0, the block SHALL shift synced DIN into an 8-bit shifter (MSB first) and increment a 3-bit bit counter.
REQ-017 The SCK edge is the only sampling event; SCK toggling while CS=1 SHALL have no effect.
REQ-018 Byte completion: on the 8th sampled bit, the block SHALL push {DC sampled on that edge, byte} into the FIFO and clear the bit counter, in the same clk cycle.
REQ-019 Latency: from the SCK pin edge to the FIFO count update SHALL be exactly 3 clk cycles.
REQ-020 Deselect: a CS rising edge with the bit counter ≠ 0 SHALL discard the partial byte, clear the counter and set the sticky FRAME_ERR flag.
REQ-021 A CS rising edge with the bit counter = 0 SHALL have no side effect.
REQ-022 Display reset: while synced RST=0, the block SHALL flush the FIFO, clear the shifter and bit counter, and ignore SCK; sticky flags SHALL be unaffected.
REQ-023 FIFO full on push: the byte SHALL be dropped, the FIFO contents SHALL be preserved, and the sticky OVERFLOW flag SHALL be set.
REQ-024 Simultaneous push and pop: both SHALL occur and the count SHALL be unchanged, including when the FIFO is full.
REQ-025 sel_dat read: rdata[7:0]=byte, rdata[8]=DC, rdata[9]=valid, all other bits 0, valid on the clk cycle after rstrb.
REQ-026 sel_dat read with the FIFO empty: rdata SHALL be 0 and no pop SHALL occur.
REQ-027 sel_stat read: bit0 nonempty, bit1 full, bit2 OVERFLOW, bit3 FRAME_ERR, bit4 synced RST level, bits[8:5] count, rest 0.
REQ-028 A sel_stat read SHALL clear OVERFLOW and FRAME_ERR after they are captured into rdata; if a set coincides with the clear, the set SHALL win.
REQ-029 rstrb with neither sel_xxx asserted SHALL leave rdata unchanged.
REQ-030 FIFO pointers SHALL be log2(FIFO_DEPTH) bits wide with natural wrap-around; count SHALL be log2(FIFO_DEPTH)+1 bits wide.

Reset
REQ-031 On reset: FIFO empty, pointers 0, shifter 0, bit counter 0, flags 0, rdata 0, irq 0.
REQ-032 On reset: synchronizer flops SHALL take idle levels, SCK=0, CS=1, DC=0, RST=1, DIN=0.
REQ-033 Reset mid-byte SHALL abort the partial byte without setting FRAME_ERR.

Structure
REQ-034 Shared package spi_oled_pkg SHALL hold the status bit indices, the rdata field indices and the FIFO_DEPTH default.
REQ-035 The FIFO SHALL be a sub-module, spi_oled_rx_fifo (synchronous, flush input, push/pop/full/empty/count).

Verification
REQ-036 Scenario: CS low, send 0xA5 with DC=0 at SCK half-period 2 clk -> stat count=1; sel_dat read returns 0x2A5.
REQ-037 Scenario: send 5 data bytes 0x01..0x05 with FIFO_DEPTH=4 and no reads -> OVERFLOW=1, reads return 0x301..0x304, then 0.
REQ-038 Scenario: 3 bits sent, then CS raised -> FRAME_ERR=1 and count=0; next full byte 0x3C (DC=1) is received intact as 0x33C.
REQ-039 Scenario: FIFO full, push and sel_dat pop in the same cycle -> count stays 4 and OVERFLOW stays 0.
REQ-040 Scenario: 2 bytes queued, then RST pulled low for 4 clk -> count=0, stat bit4=0 during the pulse; SCK edges during RST low are ignored.
REQ-041 Scenario: reset asserted mid-byte -> all outputs 0; the next byte after release is received correctly.
